serpent_subkey_store: RTL and testbench
=======================================

# serpent_subkey_store

Subkey buffer on the consumer side of the Serpent key schedule. It captures the 33 128-bit round subkeys written by the key schedule (subkey, address, valid), tracks which addresses have been filled, and on request streams them to the Serpent round datapath over a valid/ready handshake. Subkeys stream in ascending order (0..32) for encryption and descending order (32..0) for decryption. It sits between the key schedule and the cipher core inside the Serpent-XTS engine.

## Interface
- NUM_SUBKEYS, 33, number of stored subkeys; legal addresses are 0..NUM_SUBKEYS-1
- KEY_W, 128, subkey width
- ADDR_W, 6, address and index width

- i_clk  in  1  clock; all logic is on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_subkey  in  KEY_W  subkey write data from the key schedule
- i_address  in  ADDR_W  subkey write address
- i_subkey_valid  in  1  write strobe; one subkey per cycle when high
- i_rekey  in  1  one-cycle pulse; invalidates the stored key set and aborts any stream
- o_keys_ready  out  1  high when all NUM_SUBKEYS addresses have been written since the last reset or rekey
- i_start  in  1  one-cycle pulse; begins a stream
- i_decrypt  in  1  stream direction, sampled with i_start: 0 = ascending, 1 = descending
- o_rk  out  KEY_W  streamed subkey
- o_rk_idx  out  ADDR_W  address of o_rk
- o_rk_valid  out  1  o_rk and o_rk_idx are valid
- i_rk_ready  in  1  consumer accepts the current key
- o_busy  out  1  a stream is in progress
- o_done  out  1  one-cycle pulse after the last key is accepted
- o_err  out  1  one-cycle pulse on an illegal request

## Operation
- Storage: NUM_SUBKEYS x KEY_W array with a registered read, so it can be inferred as RAM. The array itself is not reset. A separate NUM_SUBKEYS-bit written mask is reset.
- Write accepted when: i_subkey_valid=1, i_address<NUM_SUBKEYS, o_busy=0 and i_rekey=0. An accepted write stores the data and sets mask[i_address].
- Rewriting an address overwrites the data; the mask stays set.
- Write with i_address>=NUM_SUBKEYS, or a write while o_busy=1: data is dropped and o_err pulses.
- o_keys_ready = AND of the mask bits (registered; it reflects the mask after the write).
- i_rekey: clears the mask and o_keys_ready, and forces the FSM to IDLE. No o_done is produced. i_rekey has priority over every other input in the same cycle.
- FSM states:
  - IDLE: waits for i_start.
    - i_start with o_keys_ready=1: latches i_decrypt, sets the first index (0 ascending, NUM_SUBKEYS-1 descending), goes to FETCH.
    - i_start with o_keys_ready=0: o_err pulses and the FSM stays in IDLE.
  - FETCH: issues the array read at the current index, goes to PRESENT.
  - PRESENT: drives o_rk_valid=1 and holds o_rk and o_rk_idx stable until i_rk_ready=1. On the handshake:
    - last index (32 ascending, 0 descending): go to IDLE and pulse o_done.
    - otherwise: step the index by +1 or -1 and go to FETCH.
- o_busy=1 in FETCH and PRESENT.
- i_start while busy is ignored and produces no error.
- Index arithmetic is ADDR_W bits wide. The index never wraps because the last-index check ends the stream first.

## Timing
- Reset values: o_keys_ready=0, o_rk=0, o_rk_idx=0, o_rk_valid=0, o_busy=0, o_done=0, o_err=0; mask=0; FSM in IDLE.
- o_keys_ready rises in the cycle after the edge that accepts the final missing write.
- i_start sampled at edge T:
  - o_busy=1 from T+1.
  - FETCH during cycle T+1.
  - o_rk_valid=1 with the first key from T+2.
- After the handshake at edge H, o_rk_valid=0 during cycle H+1 (FETCH) and the next key is valid from H+2. With i_rk_ready held at 1, a full stream takes 2*NUM_SUBKEYS cycles.
- The final handshake at edge H makes o_done=1 and o_busy=0 during cycle H+1. A new i_start is accepted at edge H+1.
- o_err is registered: it is high for the single cycle after the offending edge.
- i_rekey at edge R: o_rk_valid, o_busy and o_keys_ready are all 0 from R+1.

## Test plan
- Write keys 0..32 with data = {4{32'h0000_00AA + addr}} in ascending order -> o_keys_ready=0 until the write of address 32 is accepted, then 1 on the next cycle.
- i_start with i_decrypt=0 and i_rk_ready tied to 1 -> o_rk_idx sequence 0..32 with matching data, first valid at T+2, 66 busy cycles, then one o_done pulse.
- i_start with i_decrypt=1 and a random i_rk_ready pattern -> indices 32..0; o_rk is held stable while valid and not ready; no key is skipped or repeated.
- Key set written except address 17 -> i_start gives an o_err pulse, o_busy stays 0; writing address 17 then sets o_keys_ready.
- Write to address 40 -> o_err pulse, mask unchanged. Write during a stream -> o_err pulse, and the stored key is unchanged when the stream is rerun.
- i_rekey during PRESENT at index 10 -> o_rk_valid=0, o_busy=0 and o_keys_ready=0 next cycle, with no o_done. i_rekey and i_subkey_valid in the same cycle -> the write is dropped and the mask is 0.

Source files
------------

// File: rtl/serpent_subkey_store_if.sv
// Write bus from the key schedule and round-key stream to the cipher core.
interface serpent_subkey_store_if #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 6
);
    logic [KEY_W-1:0]  subkey;
    logic [ADDR_W-1:0] address;
    logic              subkey_valid;
    logic [KEY_W-1:0]  rk;
    logic [ADDR_W-1:0] rk_idx;
    logic              rk_valid;
    logic              rk_ready;

    modport master (
        output subkey, address, subkey_valid, rk_ready,
        input  rk, rk_idx, rk_valid
    );

    modport slave (
        input  subkey, address, subkey_valid, rk_ready,
        output rk, rk_idx, rk_valid
    );
endinterface

// File: rtl/serpent_subkey_store.sv
// Serpent subkey buffer: captures 33 round keys, tracks fill state, and streams
// them ascending (encrypt) or descending (decrypt) over a valid/ready handshake.
module serpent_subkey_store #(
    parameter int NUM_SUBKEYS = 33,
    parameter int KEY_W       = 128,
    parameter int ADDR_W      = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    serpent_subkey_store_if.slave  bus,
    input  logic                   i_rekey,
    input  logic                   i_start,
    input  logic                   i_decrypt,
    output logic                   o_keys_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t                 state, state_nxt;
    logic [KEY_W-1:0]       mem [NUM_SUBKEYS];
    logic [NUM_SUBKEYS-1:0] mask, mask_nxt;
    logic [ADDR_W-1:0]      idx;
    logic                   dir;
    logic [KEY_W-1:0]       rk_q;
    logic                   addr_ok, we, hs, last, busy, launch;

    assign busy     = (state != IDLE);
    assign addr_ok  = (bus.address < ADDR_W'(NUM_SUBKEYS));
    assign we       = bus.subkey_valid && addr_ok && !busy && !i_rekey;
    assign hs       = (state == PRESENT) && bus.rk_ready;
    assign last     = dir ? (idx == '0) : (idx == ADDR_W'(NUM_SUBKEYS - 1));
    assign launch   = (state == IDLE) && i_start && o_keys_ready;
    assign mask_nxt = mask | (we ? (NUM_SUBKEYS'(1) << bus.address) : '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_rekey) state <= IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = FETCH;
            FETCH:   state_nxt = PRESENT;
            PRESENT: if (hs) state_nxt = last ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = busy;
        bus.rk_valid = (state == PRESENT);
        bus.rk       = rk_q;
        bus.rk_idx   = idx;
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (we) mem[bus.address] <= bus.subkey;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mask         <= '0;
            o_keys_ready <= 1'b0;
            idx          <= '0;
            dir          <= 1'b0;
            rk_q         <= '0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else if (i_rekey) begin
            mask         <= '0;
            o_keys_ready <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            mask         <= mask_nxt;
            o_keys_ready <= &mask_nxt;
            o_done       <= hs && last;
            o_err        <= (bus.subkey_valid && (!addr_ok || busy)) ||
                            (i_start && (state == IDLE) && !o_keys_ready);
            if (launch) begin
                dir <= i_decrypt;
                idx <= i_decrypt ? ADDR_W'(NUM_SUBKEYS - 1) : '0;
            end else if (hs && !last) begin
                idx <= dir ? idx - 1'b1 : idx + 1'b1;
            end
            if (state == FETCH) rk_q <= mem[idx];
        end
    end
endmodule

// File: tb/tb_serpent_subkey_store.sv
// Directed bench for serpent_subkey_store with immediate-assertion checks.
module tb_serpent_subkey_store;
    logic i_clk = 1'b0;
    logic i_rst, i_rekey, i_start, i_decrypt;
    logic o_keys_ready, o_busy, o_done, o_err;
    int   n_tests = 0;
    int   n_fail  = 0;

    serpent_subkey_store_if #(.KEY_W(128), .ADDR_W(6)) bus ();

    serpent_subkey_store #(.NUM_SUBKEYS(33), .KEY_W(128), .ADDR_W(6)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .bus          (bus),
        .i_rekey      (i_rekey),
        .i_start      (i_start),
        .i_decrypt    (i_decrypt),
        .o_keys_ready (o_keys_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [127:0] kd(input int a);
        logic [31:0] w;
        w = 32'h0000_00AA + 32'(a);
        return {4{w}};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [127:0] d);
        bus.subkey_valid = 1'b1;
        bus.address      = 6'(a);
        bus.subkey       = d;
        step();
        bus.subkey_valid = 1'b0;
    endtask

    // Follows a stream already in flight with random ready, expecting every key once.
    task automatic run_stream(input bit dec, input string tag);
        int exp_i;
        int n_hs;
        bit got_done;
        exp_i    = dec ? 32 : 0;
        n_hs     = 0;
        got_done = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            bus.rk_ready = 1'($urandom_range(0, 1));
            if (o_done) got_done = 1'b1;
            else if (bus.rk_valid) begin
                chk({tag, "_idx"}, 128'(bus.rk_idx), 128'(exp_i[5:0]));
                chk({tag, "_data"}, bus.rk, kd(exp_i));
                if (bus.rk_ready) begin
                    n_hs++;
                    exp_i = dec ? exp_i - 1 : exp_i + 1;
                end
            end
            if (!got_done) step();
        end
        bus.rk_ready = 1'b0;
        chk({tag, "_handshakes"}, 128'(n_hs), 128'd33);
        chk({tag, "_done_seen"}, 128'(got_done), 128'd1);
    endtask

    initial begin
        bit found;
        i_rst = 1'b1; i_rekey = 1'b0; i_start = 1'b0; i_decrypt = 1'b0;
        bus.subkey = '0; bus.address = '0; bus.subkey_valid = 1'b0; bus.rk_ready = 1'b0;
        step(); step();
        chk("rst_keys_ready", 128'(o_keys_ready), 128'd0);
        chk("rst_rk", bus.rk, 128'd0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("rst_rk_valid", 128'(bus.rk_valid), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_done", 128'(o_done), 128'd0);
        chk("rst_err", 128'(o_err), 128'd0);
        i_rst = 1'b0;

        for (int a = 0; a < 33; a++) begin
            wr(a, kd(a));
            chk("fill_keys_ready", 128'(o_keys_ready), 128'(a == 32));
        end

        wr(40, '1);
        chk("bad_addr_err", 128'(o_err), 128'd1);
        chk("bad_addr_ready", 128'(o_keys_ready), 128'd1);
        step();
        chk("bad_addr_err_clear", 128'(o_err), 128'd0);

        // Ascending stream with ready held high: exact cycle timing.
        bus.rk_ready = 1'b1;
        i_start = 1'b1; i_decrypt = 1'b0;
        step();
        i_start = 1'b0;
        chk("enc_t1_busy", 128'(o_busy), 128'd1);
        chk("enc_t1_valid", 128'(bus.rk_valid), 128'd0);
        for (int i = 0; i < 33; i++) begin
            step();
            chk("enc_valid", 128'(bus.rk_valid), 128'd1);
            chk("enc_idx", 128'(bus.rk_idx), 128'(i));
            chk("enc_data", bus.rk, kd(i));
            chk("enc_busy", 128'(o_busy), 128'd1);
            step();
            if (i < 32) begin
                chk("enc_fetch_valid", 128'(bus.rk_valid), 128'd0);
                chk("enc_fetch_busy", 128'(o_busy), 128'd1);
            end else begin
                chk("enc_done", 128'(o_done), 128'd1);
                chk("enc_end_busy", 128'(o_busy), 128'd0);
            end
        end
        step();
        chk("enc_done_pulse", 128'(o_done), 128'd0);
        bus.rk_ready = 1'b0;

        // Descending stream with random backpressure.
        i_start = 1'b1; i_decrypt = 1'b1;
        step();
        i_start = 1'b0;
        run_stream(1'b1, "dec");

        // Missing address 17 blocks the start.
        i_rekey = 1'b1;
        step();
        i_rekey = 1'b0;
        chk("rekey_ready", 128'(o_keys_ready), 128'd0);
        for (int a = 0; a < 33; a++)
            if (a != 17) wr(a, kd(a));
        chk("miss17_ready", 128'(o_keys_ready), 128'd0);
        i_start = 1'b1; i_decrypt = 1'b0;
        step();
        i_start = 1'b0;
        chk("miss17_err", 128'(o_err), 128'd1);
        chk("miss17_busy", 128'(o_busy), 128'd0);
        step();
        chk("miss17_busy_after", 128'(o_busy), 128'd0);
        wr(17, kd(17));
        chk("fill17_ready", 128'(o_keys_ready), 128'd1);

        // Write while streaming is dropped; stored key 5 must survive.
        i_start = 1'b1; i_decrypt = 1'b0;
        step();
        i_start = 1'b0;
        wr(5, '1);
        chk("busy_write_err", 128'(o_err), 128'd1);
        run_stream(1'b0, "rerun");

        // Rekey while presenting index 10.
        i_start = 1'b1; i_decrypt = 1'b0;
        step();
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.rk_valid && bus.rk_idx == 6'd10) begin
                found = 1'b1;
                break;
            end
            bus.rk_ready = 1'b1;
            step();
        end
        chk("rk10_reached", 128'(found), 128'd1);
        bus.rk_ready = 1'b1;
        i_rekey = 1'b1;
        step();
        i_rekey = 1'b0;
        chk("rk10_valid", 128'(bus.rk_valid), 128'd0);
        chk("rk10_busy", 128'(o_busy), 128'd0);
        chk("rk10_ready", 128'(o_keys_ready), 128'd0);
        chk("rk10_done", 128'(o_done), 128'd0);
        step();
        chk("rk10_done_late", 128'(o_done), 128'd0);
        bus.rk_ready = 1'b0;

        // Rekey beats a coincident write: address 0 must remain unfilled.
        bus.subkey_valid = 1'b1; bus.address = 6'd0; bus.subkey = kd(0);
        i_rekey = 1'b1;
        step();
        i_rekey = 1'b0;
        bus.subkey_valid = 1'b0;
        for (int a = 1; a < 33; a++) wr(a, kd(a));
        chk("rekey_write_dropped", 128'(o_keys_ready), 128'd0);
        wr(0, kd(0));
        chk("rekey_write_refill", 128'(o_keys_ready), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
